uart_ctrl_sequencer: RTL



---
 rtl/uart_ctrl_pkg.sv | 14 +
 rtl/uart_ctrl_sequencer_if.sv | 10 +
 rtl/uart_ctrl_cmd_fifo.sv | 43 ++++
 rtl/uart_ctrl_sequencer.sv | 77 +++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: register addresses, status bit positions and sequencer states
package uart_ctrl_pkg;
  localparam logic [1:0] ADDR_CMD  = 2'd0;
  localparam logic [1:0] ADDR_IDLE = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_CNT   = 3;
  localparam int ST_OVF   = 8;
  localparam int WR_FLUSH = 0;
  localparam int WR_OCLR  = 8;
  typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/uart_ctrl_sequencer_if.sv
// uart_ctrl_sequencer_if: Avalon-MM slave bus (address, chipselect, write_n, writedata, readdata)
interface uart_ctrl_sequencer_if;
  logic [1:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/uart_ctrl_cmd_fifo.sv
// uart_ctrl_cmd_fifo: command FIFO (clk, reset_n, flush, push/din, pop/dout, full, empty, count); push when full needs a same-cycle pop
module uart_ctrl_cmd_fifo #(
  parameter int W = 24,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push_ok, pop_ok;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign pop_ok = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push_ok ? wp + 1'b1 : wp;
      rp <= pop_ok ? rp + 1'b1 : rp;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
endmodule

// File: rtl/uart_ctrl_sequencer.sv
// uart_ctrl_sequencer: plays queued {hold, word} commands on ctrl_out back-to-back, then idle_word (clk, reset_n, bus slave, ctrl_out, busy, done)
module uart_ctrl_sequencer
  import uart_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_W = 16
) (
  input  logic clk,
  input  logic reset_n,
  uart_ctrl_sequencer_if.slave bus,
  output logic [7:0] ctrl_out,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_t state, state_n;
  logic [HOLD_W-1:0] cnt, cnt_n, hold, load;
  logic [7:0] idle_word, ctrl_n;
  logic [8+HOLD_W-1:0] dout;
  logic [CW-1:0] count;
  logic [31:0] stat;
  logic wr, push, pop, flush, oclr, full, empty, ovf, done_n, unused_wd;
  assign unused_wd = ^bus.writedata;
  assign wr = bus.chipselect && !bus.write_n;
  assign push = wr && bus.address == ADDR_CMD;
  assign flush = wr && bus.address == ADDR_STAT && bus.writedata[WR_FLUSH];
  assign oclr = wr && bus.address == ADDR_STAT && bus.writedata[WR_OCLR];
  assign busy = state == HOLD;
  uart_ctrl_cmd_fifo #(.W(8 + HOLD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush),
    .push(push),
    .pop(pop),
    .din({bus.writedata[8 +: HOLD_W], bus.writedata[7:0]}),
    .dout(dout),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    hold = dout[8 +: HOLD_W];
    load = hold == '0 ? '0 : hold - 1'b1;
    pop = !flush && !empty && (state == IDLE || cnt == '0);
    state_n = flush ? IDLE : pop ? HOLD : (state == HOLD && cnt != '0) ? HOLD : IDLE;
    cnt_n = pop ? load : cnt != '0 ? cnt - 1'b1 : cnt;
    ctrl_n = pop ? dout[7:0] : state_n == IDLE ? idle_word : ctrl_out;
    done_n = !flush && state == HOLD && cnt == '0 && empty;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      ctrl_out <= '0;
      done <= 1'b0;
      idle_word <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ctrl_out <= ctrl_n;
      done <= done_n;
      idle_word <= (wr && bus.address == ADDR_IDLE) ? bus.writedata[7:0] : idle_word;
      ovf <= oclr ? 1'b0 : (push && full && !pop) ? 1'b1 : ovf;
    end
  always_comb begin
    stat = '0;
    stat[ST_BUSY] = busy;
    stat[ST_FULL] = full;
    stat[ST_EMPTY] = empty;
    stat[ST_CNT +: 3] = 3'(count);
    stat[ST_OVF] = ovf;
    bus.readdata = bus.address == ADDR_CMD ? {24'd0, ctrl_out} :
                   bus.address == ADDR_IDLE ? {24'd0, idle_word} :
                   bus.address == ADDR_STAT ? stat : '0;
  end
endmodule
